// File: rtl/instr_mem_if.sv
// instr_mem_if: fetch and program-loader signals of the instruction memory.
//   master : fetch stage / loader source (drives address and load bytes)
//   slave  : instr_mem (returns instruction words, stall/fault, load status)
//   Fetch   : instruction_rd1 (20b addr), instruction_rd1_out (16b word),
//             fetch_stall, fetch_fault
//   Loader  : load_start, load_base (20b), load_count (16b), load_byte (8b),
//             load_valid, load_ready, load_done, load_error
interface instr_mem_if;
  logic [19:0] instruction_rd1;
  logic [15:0] instruction_rd1_out;
  logic        fetch_stall;
  logic        fetch_fault;
  logic        load_start;
  logic [19:0] load_base;
  logic [15:0] load_count;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        load_error;

  modport master (
    output instruction_rd1, load_start, load_base, load_count, load_byte, load_valid,
    input  instruction_rd1_out, fetch_stall, fetch_fault, load_ready, load_done, load_error
  );

  modport slave (
    input  instruction_rd1, load_start, load_base, load_count, load_byte, load_valid,
    output instruction_rd1_out, fetch_stall, fetch_fault, load_ready, load_done, load_error
  );
endinterface

// File: rtl/instr_mem.sv
// instr_mem: single-port instruction memory of 2**ADDR_BITS 16-bit words with
// a one-cycle synchronous read for the fetch stage and a byte-serial program
// loader (little-endian byte pairs, valid/ready handshake).
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset (memory contents are kept)
//   bus     : instr_mem_if.slave, fetch read port plus loader handshake
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | fetch reads served; waiting for load_start
// LOAD_LO | loader waiting for the low byte of the current word
// LOAD_HI | loader waiting for the high byte; word written on accept
// DONE    | load finished; load_done pulses for this one cycle
module instr_mem #(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] NOP_WORD  = 16'h0000
) (
  input logic       clock,
  input logic       reset_n,
  instr_mem_if.slave bus
);

  localparam int          DEPTH     = 1 << ADDR_BITS;
  localparam logic [20:0] DEPTH_EXT = 21'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] waddr_q;
  logic [15:0] remaining_q;
  logic [7:0]  low_byte_q;
  logic        load_ready_q;
  logic        fetch_stall_q;
  logic        load_done_q;
  logic        load_error_q;
  logic [15:0] rd_data_q;
  logic        rd_fault_q;

  logic [15:0] mem [DEPTH];

  logic byte_fire;
  logic waddr_in_range;
  logic raddr_in_range;
  logic rd_en;
  logic wr_en;

  assign byte_fire      = bus.load_valid && load_ready_q;
  assign waddr_in_range = {1'b0, waddr_q} < DEPTH_EXT;
  assign raddr_in_range = {1'b0, bus.instruction_rd1} < DEPTH_EXT;
  assign wr_en          = (state_q == LOAD_HI) && byte_fire && waddr_in_range;

  // Reads happen only when the machine is idle now and stays idle, so the
  // output is already NOP on every cycle that fetch_stall is high, including
  // the first loading cycle after load_start.
  assign rd_en = (state_q == IDLE) && (state_d == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = (bus.load_count == 16'd0) ? DONE : LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (byte_fire) state_d = LOAD_HI;
      end
      LOAD_HI: begin
        if (byte_fire) state_d = (remaining_q == 16'd1) ? DONE : LOAD_LO;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control FSM: state, loader bookkeeping and all status outputs are
  // registered from the next state, so they line up with state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      waddr_q       <= 20'd0;
      remaining_q   <= 16'd0;
      low_byte_q    <= 8'd0;
      load_ready_q  <= 1'b0;
      fetch_stall_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_stall_q <= (state_d != IDLE);
      load_ready_q  <= (state_d == LOAD_LO) || (state_d == LOAD_HI);
      load_done_q   <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (bus.load_start) begin
            waddr_q      <= bus.load_base;
            remaining_q  <= bus.load_count;
            load_error_q <= 1'b0;
          end
        end
        LOAD_LO: begin
          if (byte_fire) low_byte_q <= bus.load_byte;
        end
        LOAD_HI: begin
          if (byte_fire) begin
            if (!waddr_in_range) load_error_q <= 1'b1;
            // 20-bit address wraps naturally from 0xFFFFF to 0
            waddr_q     <= waddr_q + 20'd1;
            remaining_q <= remaining_q - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset so a mid-load reset keeps already written words.
  always_ff @(posedge clock) begin
    if (wr_en) mem[waddr_q[ADDR_BITS-1:0]] <= {bus.load_byte, low_byte_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= NOP_WORD;
      rd_fault_q <= 1'b0;
    end else if (rd_en) begin
      if (raddr_in_range) begin
        rd_data_q  <= mem[bus.instruction_rd1[ADDR_BITS-1:0]];
        rd_fault_q <= 1'b0;
      end else begin
        rd_data_q  <= NOP_WORD;
        rd_fault_q <= 1'b1;
      end
    end else begin
      rd_data_q  <= NOP_WORD;
      rd_fault_q <= 1'b0;
    end
  end

  assign bus.instruction_rd1_out = rd_data_q;
  assign bus.fetch_fault         = rd_fault_q;
  assign bus.fetch_stall         = fetch_stall_q;
  assign bus.load_ready          = load_ready_q;
  assign bus.load_done           = load_done_q;
  assign bus.load_error          = load_error_q;

endmodule
